// File: rtl/mac_sequencer.sv
// Sequencer and multiply-accumulate datapath that computes every element of an
// N x N matrix product and hands each dot product to the result register.
module mac_sequencer #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              res_clear,
  output logic              res_write,
  output logic [ACC_W-1:0]  res_data,
  output logic [ADDR_W-1:0] res_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  // Unsigned product zero-extended into the accumulator; the sum wraps.
  function automatic logic [ACC_W-1:0] mac_wrap(input logic [ACC_W-1:0]  acc,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] prod;
    prod = a * b;
    return acc + ACC_W'(prod);
  endfunction

  function automatic logic [ADDR_W-1:0] flat(input logic [ADDR_W-1:0] row,
                                             input logic [ADDR_W-1:0] col);
    return row * ADDR_W'(N) + col;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              rd_v_q, rd_v_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    rd_v_d    = 1'b0;
    a_addr_d  = a_addr_q;
    b_addr_d  = b_addr_q;
    res_clear = 1'b0;
    res_write = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    // Operand data returns one cycle after its address, tracked by rd_v.
    acc_d     = rd_v_q ? mac_wrap(acc_q, a_data, b_data) : acc_q;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_CLEAR;
          i_d     = '0;
          j_d     = '0;
        end
      end
      S_CLEAR: begin
        res_clear = 1'b1;
        acc_d     = '0;
        k_d       = '0;
        state_d   = S_FETCH;
      end
      S_FETCH: begin
        a_addr_d = flat(i_q, k_q);
        b_addr_d = flat(k_q, j_q);
        rd_v_d   = 1'b1;
        k_d      = k_q + 1'b1;
        if (k_q == LAST) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        res_write = 1'b1;
        if (j_q != LAST) begin
          j_d     = j_q + 1'b1;
          state_d = S_CLEAR;
        end else if (i_q != LAST) begin
          j_d     = '0;
          i_d     = i_q + 1'b1;
          state_d = S_CLEAR;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Addresses are live during FETCH and otherwise hold the last issued value.
  assign a_addr   = a_addr_d;
  assign b_addr   = b_addr_d;
  assign res_data = acc_q;
  assign res_idx  = flat(i_q, j_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      rd_v_q   <= 1'b0;
      a_addr_q <= '0;
      b_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      rd_v_q   <= rd_v_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: synchronous operand RAMs, a write/done
// monitor, and one task per scenario with hand-computed expectations.
module tb_mac_sequencer;

  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 18;
  localparam int ADDR_W = 4;
  localparam int LOG    = 4096;
  localparam int WLOG   = 512;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              res_clear, res_write;
  logic [ACC_W-1:0]  res_data;
  logic [ADDR_W-1:0] res_idx;
  logic              busy, done;

  always #5 clk = ~clk;

  mac_sequencer #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_addr(a_addr), .b_addr(b_addr), .a_data(a_data), .b_data(b_data),
    .res_clear(res_clear), .res_write(res_write), .res_data(res_data),
    .res_idx(res_idx), .busy(busy), .done(done)
  );

  logic [DATA_W-1:0] a_mem [16];
  logic [DATA_W-1:0] b_mem [16];

  always @(posedge clk) begin
    a_data <= a_mem[a_addr];
    b_data <= b_mem[b_addr];
  end

  // Monitor: cyc equals the number of rising edges seen so far.
  int                cyc = 0;
  int                wr_total = 0;
  int                done_total = 0;
  int                done_cyc = 0;
  int                both_cnt = 0;
  logic [ADDR_W-1:0] wr_idx  [WLOG];
  logic [ACC_W-1:0]  wr_data [WLOG];
  int                wr_cyc  [WLOG];
  bit                clr_bit [LOG];
  logic [ADDR_W-1:0] a_log   [LOG];
  logic [ADDR_W-1:0] b_log   [LOG];

  always begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (cyc < LOG) begin
      clr_bit[cyc] = res_clear;
      a_log[cyc]   = a_addr;
      b_log[cyc]   = b_addr;
    end
    if (res_write && wr_total < WLOG) begin
      wr_idx[wr_total]  = res_idx;
      wr_data[wr_total] = res_data;
      wr_cyc[wr_total]  = cyc;
      wr_total = wr_total + 1;
    end
    if (res_write && res_clear) both_cnt = both_cnt + 1;
    if (done) begin
      done_total = done_total + 1;
      done_cyc   = cyc;
    end
  end

  int checks = 0;
  int failures = 0;
  int run_base, run_wr, run_done;
  bit run_ok;

  task automatic run_and_wait();
    int d0;
    d0 = done_total;
    @(negedge clk);
    start    = 1'b1;
    run_base = cyc;
    run_wr   = wr_total;
    run_done = d0;
    @(negedge clk);
    start  = 1'b0;
    run_ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (done_total != d0) begin
        run_ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic load_identity();
    for (int e = 0; e < 16; e++) begin
      a_mem[e] = (e / 4 == e % 4) ? 8'd1 : 8'd0;
      b_mem[e] = DATA_W'(e + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, res_clear, res_write} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0000", {busy, done, res_clear, res_write});
    end
    checks++;
    if ({a_addr, b_addr, res_idx} !== '0) begin
      failures++;
      $display("FAIL reset_addr got a=%0d b=%0d idx=%0d want 0", a_addr, b_addr, res_idx);
    end
    checks++;
    if (res_data !== '0) begin
      failures++;
      $display("FAIL reset_data got=%0d want=0", res_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_clear !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start busy=%b clear=%b want 0 0", busy, res_clear);
    end
  endtask

  task automatic test_identity();
    load_identity();
    run_and_wait();
    checks++;
    if (!run_ok) begin
      failures++;
      $display("FAIL identity_timeout got no done want done");
    end
    checks++;
    if (done_cyc - run_base !== 113) begin
      failures++;
      $display("FAIL identity_latency got=%0d want=113", done_cyc - run_base);
    end
    checks++;
    if (wr_total - run_wr !== 16) begin
      failures++;
      $display("FAIL identity_count got=%0d want=16", wr_total - run_wr);
    end
    for (int e = 0; e < 16; e++) begin
      checks++;
      if (wr_idx[run_wr+e] !== ADDR_W'(e) || wr_data[run_wr+e] !== ACC_W'(e + 1)) begin
        failures++;
        $display("FAIL identity_elem%0d got idx=%0d data=%0d want idx=%0d data=%0d",
                 e, wr_idx[run_wr+e], wr_data[run_wr+e], e, e + 1);
      end
    end
  endtask

  task automatic test_max();
    for (int e = 0; e < 16; e++) begin
      a_mem[e] = 8'd255;
      b_mem[e] = 8'd255;
    end
    run_and_wait();
    checks++;
    if (!run_ok || wr_total - run_wr !== 16) begin
      failures++;
      $display("FAIL max_count got=%0d ok=%0d want=16", wr_total - run_wr, run_ok);
    end
    for (int e = 0; e < 16; e++) begin
      checks++;
      if (wr_data[run_wr+e] !== 18'h3F804) begin
        failures++;
        $display("FAIL max_elem%0d got=%0d want=260100", e, wr_data[run_wr+e]);
      end
    end
  endtask

  task automatic test_zero_a();
    for (int e = 0; e < 16; e++) begin
      a_mem[e] = 8'd0;
      b_mem[e] = DATA_W'($urandom_range(0, 255));
    end
    run_and_wait();
    checks++;
    if (!run_ok || wr_total - run_wr !== 16) begin
      failures++;
      $display("FAIL zero_count got=%0d ok=%0d want=16", wr_total - run_wr, run_ok);
    end
    for (int e = 0; e < 16; e++) begin
      checks++;
      if (wr_data[run_wr+e] !== '0) begin
        failures++;
        $display("FAIL zero_elem%0d got=%0d want=0", e, wr_data[run_wr+e]);
      end
      checks++;
      if (clr_bit[wr_cyc[run_wr+e] - (N + 2)] !== 1'b1) begin
        failures++;
        $display("FAIL zero_clear_gap%0d got=0 want clear %0d cycles before write", e, N + 2);
      end
    end
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL clear_write_overlap got=%0d want=0", both_cnt);
    end
  endtask

  task automatic test_rowcol();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        a_mem[r*4+c] = DATA_W'(r + 1);
        b_mem[r*4+c] = DATA_W'(c + 1);
      end
    end
    run_and_wait();
    checks++;
    if (!run_ok || wr_total - run_wr !== 16) begin
      failures++;
      $display("FAIL rowcol_count got=%0d ok=%0d want=16", wr_total - run_wr, run_ok);
    end
    for (int e = 0; e < 16; e++) begin
      checks++;
      if (wr_data[run_wr+e] !== ACC_W'(4 * (e / 4 + 1) * (e % 4 + 1))) begin
        failures++;
        $display("FAIL rowcol_elem%0d got=%0d want=%0d", e, wr_data[run_wr+e],
                 4 * (e / 4 + 1) * (e % 4 + 1));
      end
    end
    checks++;
    if (wr_idx[run_wr+15] !== 4'd15 || wr_data[run_wr+15] !== 18'd64) begin
      failures++;
      $display("FAIL rowcol_c33 got idx=%0d data=%0d want idx=15 data=64",
               wr_idx[run_wr+15], wr_data[run_wr+15]);
    end
    // Element (1,2) is element 6: CLEAR at index 43, FETCH at 44..47.
    for (int t = 0; t < 4; t++) begin
      checks++;
      if (a_log[run_base+44+t] !== ADDR_W'(4 + t) || b_log[run_base+44+t] !== ADDR_W'(2 + 4 * t)) begin
        failures++;
        $display("FAIL rowcol_addr%0d got a=%0d b=%0d want a=%0d b=%0d", t,
                 a_log[run_base+44+t], b_log[run_base+44+t], 4 + t, 2 + 4 * t);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base, wr0, d0;
    load_identity();
    @(negedge clk);
    start = 1'b1;
    base = cyc;
    wr0 = wr_total;
    d0 = done_total;
    @(negedge clk);
    start = 1'b0;
    // Element 5 occupies FETCH at indices 37..40.
    for (int t = 0; t < 100 && (cyc - base) < 38; t++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_busy got=%b want=0", busy);
    end
    rst = 1'b0;
    checks++;
    if (wr_total - wr0 !== 5) begin
      failures++;
      $display("FAIL rstmid_writes_before got=%0d want=5", wr_total - wr0);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (wr_total - wr0 !== 5 || done_total !== d0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_quiet got writes=%0d dones=%0d busy=%b want 5 0 0",
               wr_total - wr0, done_total - d0, busy);
    end
    run_and_wait();
    checks++;
    if (!run_ok || wr_total - run_wr !== 16) begin
      failures++;
      $display("FAIL rstmid_rerun_count got=%0d ok=%0d want=16", wr_total - run_wr, run_ok);
    end
    for (int e = 0; e < 16; e++) begin
      checks++;
      if (wr_idx[run_wr+e] !== ADDR_W'(e) || wr_data[run_wr+e] !== ACC_W'(e + 1)) begin
        failures++;
        $display("FAIL rstmid_elem%0d got idx=%0d data=%0d want idx=%0d data=%0d",
                 e, wr_idx[run_wr+e], wr_data[run_wr+e], e, e + 1);
      end
    end
  endtask

  task automatic test_start_busy();
    int base, wr0, d0, idx;
    load_identity();
    @(negedge clk);
    start = 1'b1;
    base = cyc;
    wr0 = wr_total;
    d0 = done_total;
    for (int t = 0; t < 130; t++) begin
      @(negedge clk);
      idx = cyc - base;
      start = (idx == 10 || idx == 50 || idx == 100 || idx == 111 || idx == 113);
    end
    start = 1'b0;
    checks++;
    if (wr_total - wr0 !== 16 || done_total - d0 !== 1) begin
      failures++;
      $display("FAIL startbusy_runs got writes=%0d dones=%0d want 16 1",
               wr_total - wr0, done_total - d0);
    end
    checks++;
    if (done_cyc - base !== 113 || busy !== 1'b0) begin
      failures++;
      $display("FAIL startbusy_timing got done_at=%0d busy=%b want 113 0", done_cyc - base, busy);
    end
  endtask

  task automatic test_back_to_back();
    int b1, w1;
    load_identity();
    run_and_wait();
    b1 = run_base;
    w1 = run_wr;
    run_and_wait();
    checks++;
    if (run_base - b1 !== 114) begin
      failures++;
      $display("FAIL b2b_start_gap got=%0d want=114", run_base - b1);
    end
    checks++;
    if (!run_ok || done_cyc - run_base !== 113) begin
      failures++;
      $display("FAIL b2b_second_latency got=%0d ok=%0d want=113", done_cyc - run_base, run_ok);
    end
    checks++;
    if (wr_total - w1 !== 32) begin
      failures++;
      $display("FAIL b2b_total_writes got=%0d want=32", wr_total - w1);
    end
    for (int e = 0; e < 16; e++) begin
      checks++;
      if (wr_idx[run_wr+e] !== ADDR_W'(e) || wr_data[run_wr+e] !== ACC_W'(e + 1)) begin
        failures++;
        $display("FAIL b2b_elem%0d got idx=%0d data=%0d want idx=%0d data=%0d",
                 e, wr_idx[run_wr+e], wr_data[run_wr+e], e, e + 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_identity();
    test_max();
    test_zero_a();
    test_rowcol();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
Upstream controller and datapath that feeds the result register in the matrix-multiplication engine. On a start pulse it walks every output element C[i][j] of an N x N product. For each element it issues addresses to the A and B operand memories, multiply-accumulates the returned operands, then drives the clear, write and data inputs of the result register. It signals completion with a one-cycle done pulse.

Parameters:
N, 4, matrix dimension; N=1..4 guarantees no 18-bit overflow.
DATA_W, 8, operand width, unsigned.
ACC_W, 18, accumulator and result width.
ADDR_W, 4, operand/result address width; must satisfy 2^ADDR_W >= N*N.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to begin a full matrix product; ignored while busy.
a_addr  out  ADDR_W  A memory read address, row-major: i*N+k.
b_addr  out  ADDR_W  B memory read address, row-major: k*N+j.
a_data  in  DATA_W  A read data, valid 1 cycle after a_addr (synchronous RAM).
b_data  in  DATA_W  B read data, valid 1 cycle after b_addr.
res_clear  out  1  clear strobe to result register.
res_write  out  1  write strobe to result register.
res_data  out  ACC_W  accumulated dot product.
res_idx  out  ADDR_W  element index i*N+j for the result being written.
busy  out  1  high while sequencing.
done  out  1  one-cycle pulse after the last element is written.

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; i, j and k = 0; acc = 0; all outputs 0. Reset mid-operation aborts at once and issues no further res_write. rst takes priority over start.
- FSM states: IDLE, CLEAR, FETCH, DRAIN, WRITE, DONE.
- IDLE: busy=0. When start=1, go to CLEAR with i=j=0.
- CLEAR (1 cycle): res_clear=1; acc <= 0; k <= 0; go to FETCH.
- FETCH (N cycles): drive a_addr=i*N+k and b_addr=k*N+j; k increments each cycle. A registered valid flag (rd_v) follows the issue by 1 cycle. When rd_v=1, acc <= acc + a_data*b_data. After issuing k=N-1, go to DRAIN.
- DRAIN (1 cycle): accumulate the final product; go to WRITE.
- WRITE (1 cycle): res_write=1; res_data=acc; res_idx=i*N+j.
  - If j<N-1: j++.
  - Else if i<N-1: j=0, i++.
  - Else go to DONE.
  - In the first two cases, return to CLEAR.
- DONE (1 cycle): done=1; go to IDLE.
- busy=1 in every state except IDLE.
- Latency: N+3 cycles per element. From the start edge to the done pulse takes N*N*(N+3)+1 cycles (N=4: 113).
- Arithmetic: product is 2*DATA_W bits unsigned, zero-extended to ACC_W; the sum wraps modulo 2^ACC_W. No wrap occurs for N<=4, since the maximum is 4*255*255 = 260100.
- res_data holds acc at all times; it is meaningful only when res_write=1. res_clear and res_write are never high in the same cycle.
- start during busy has no effect. start in the same cycle as DONE has no effect. start in IDLE is accepted the next cycle.
- Address outputs hold their last value outside FETCH.

Test Plan:
1. A=identity, B=1..16 row-major, N=4, pulse start → 16 writes, res_idx 0..15 in order, res_data=1..16; done 113 cycles after start.
2. A=B=all 255 → every res_data=260100 (0x3F804); no wrap.
3. A=all 0, B=random → 16 writes of res_data=0; each write preceded by a res_clear pulse exactly N+2 cycles earlier.
4. A[i][k]=i+1, B[k][j]=j+1 → C[i][j]=4*(i+1)*(j+1); check C[3][3]=64 at res_idx 15; check the address sequence for element (1,2): a_addr 4,5,6,7 and b_addr 2,6,10,14.
5. Assert rst during element 5 FETCH → next cycle busy=0, no res_write, done never pulses. A new start then gives a full correct run from element 0.
6. Pulse start repeatedly while busy, and once in the DONE cycle → exactly one run of 16 writes; a start one cycle after DONE launches a second run.
